// File: rtl/z80_mem_responder.sv
// z80_mem_responder: memory-side responder for the Z80 core bus.
// Owns a 2^ADDR_W byte RAM. After reset it runs a boot-load phase (LOAD)
// that streams BOOT_LEN loader bytes into RAM starting at BOOT_BASE while
// holding the core in reset, then switches to RUN, where the core reads
// through a falling-edge latch and writes on the rising edge.
// Optional feature: define Z80_ROM_PROTECT_EN to drop CPU writes below
// ROM_TOP while in RUN (loader writes are never protected).
module z80_mem_responder #(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] BOOT_BASE = 16'h0000,
  parameter int          BOOT_LEN  = 256,
  parameter logic [15:0] ROM_TOP   = 16'h4000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        we,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        cpu_reset,
  input  logic [7:0]  boot_data,
  input  logic        boot_valid,
  output logic        boot_ready,
  output logic        boot_done
);

  localparam int CNT_W = (BOOT_LEN > 0) ? $clog2(BOOT_LEN + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'((BOOT_LEN > 0) ? BOOT_LEN - 1 : 0);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BOOT_BASE);

`ifdef Z80_ROM_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              cpu_reset_n, boot_done_n;

  logic [7:0]        mem [0:(2**ADDR_W)-1];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [ADDR_W-1:0] load_addr;
  logic              wr_blocked;

  // Loader destination wraps modulo the RAM size.
  assign load_addr  = BASE_A + ADDR_W'(count);

  // Only meaningful when protection is compiled in; otherwise always clear.
  assign wr_blocked = PROTECT && (address < ROM_TOP);

  // Ready is dropped immediately while reset is high so a byte offered in the
  // reset cycle is never taken.
  assign boot_ready = (state == LOAD) && !reset && (BOOT_LEN > 0);

  // State register plus boot counter and the sticky status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOAD;
      count     <= '0;
      cpu_reset <= 1'b1;
      boot_done <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      cpu_reset <= cpu_reset_n;
      boot_done <= boot_done_n;
    end
  end

  // Next-state logic and selection of the single RAM write port.
  always_comb begin
    state_n     = state;
    count_n     = count;
    cpu_reset_n = cpu_reset;
    boot_done_n = boot_done;
    ram_we      = 1'b0;
    ram_addr    = address[ADDR_W-1:0];
    ram_wdata   = wdata;
    case (state)
      LOAD: begin
        if (BOOT_LEN == 0) begin
          if (!reset) begin
            state_n     = RUN;
            cpu_reset_n = 1'b0;
            boot_done_n = 1'b1;
          end
        end else if (boot_valid && boot_ready) begin
          ram_we    = 1'b1;
          ram_addr  = load_addr;
          ram_wdata = boot_data;
          count_n   = count + CNT_W'(1);
          if (count == LAST) begin
            state_n     = RUN;
            cpu_reset_n = 1'b0;
            boot_done_n = 1'b1;
          end
        end
      end
      RUN: begin
        cpu_reset_n = 1'b0;
        if (we && !wr_blocked && !reset) begin
          ram_we = 1'b1;
        end
      end
      default: begin
        state_n = LOAD;
      end
    endcase
  end

  // RAM write port, shared by the loader (LOAD) and the CPU (RUN).
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // Falling-edge read latch: gives the core a half-cycle read and sees writes
  // committed on the preceding rising edge; outputs NOP outside RUN.
  always_ff @(negedge clock) begin
    if (reset || (state != RUN)) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[address[ADDR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_z80_mem_responder.sv
// tb_z80_mem_responder: self-checking bench for z80_mem_responder.
// Main instance uses BOOT_LEN=4 at base 0; a second instance uses BOOT_LEN=0.
// Read expectations go through a scoreboard queue and are compared when the
// falling-edge read data appears.
module tb_z80_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        we;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        cpu_reset;
  logic [7:0]  boot_data;
  logic        boot_valid;
  logic        boot_ready;
  logic        boot_done;

  logic [7:0]  rdata0;
  logic        cpu_reset0;
  logic        boot_ready0;
  logic        boot_done0;

  always #5 clock = ~clock;

  z80_mem_responder #(
    .ADDR_W(16), .BOOT_BASE(16'h0000), .BOOT_LEN(4), .ROM_TOP(16'h4000)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .we(we), .wdata(wdata),
    .rdata(rdata), .cpu_reset(cpu_reset), .boot_data(boot_data),
    .boot_valid(boot_valid), .boot_ready(boot_ready), .boot_done(boot_done)
  );

  z80_mem_responder #(
    .ADDR_W(16), .BOOT_BASE(16'h0000), .BOOT_LEN(0), .ROM_TOP(16'h4000)
  ) dut0 (
    .clock(clock), .reset(reset), .address(address), .we(we), .wdata(wdata),
    .rdata(rdata0), .cpu_reset(cpu_reset0), .boot_data(boot_data),
    .boot_valid(boot_valid), .boot_ready(boot_ready0), .boot_done(boot_done0)
  );

`ifdef Z80_ROM_PROTECT_EN
  localparam logic [7:0] EXP_RAM1 = 8'h55;
`else
  localparam logic [7:0] EXP_RAM1 = 8'hFF;
`endif

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          check;
    logic [7:0]  exp;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  exp_q[$];
  logic [15:0] tag_q[$];
  logic [7:0]  stream[4];

  int n_vec  = 0;
  int n_miss = 0;
  bit ready0_seen = 1'b0;

  int cycles, ready_cnt, cr_low;

  // The BOOT_LEN=0 instance must never offer ready.
  always @(negedge clock) begin
    if (boot_ready0 === 1'b1) ready0_seen = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input bit chk, input logic [7:0] e);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.check = chk; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    we      = v.we;
    address = v.addr;
    wdata   = v.wdata;
    if (v.check) begin
      exp_q.push_back(v.exp);
      tag_q.push_back(v.addr);
    end
  endtask

  // Each vector is driven just after a rising edge; rdata is compared just
  // after the following falling edge.
  task automatic run_table();
    logic [7:0]  e;
    logic [15:0] t;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      @(negedge clock); #1;
      if (tbl[i].check) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput($sformatf("rd@%h", t), {8'h00, rdata}, {8'h00, e});
      end
      @(posedge clock); #1;
    end
    we = 1'b0;
    tbl.delete();
  endtask

  // Streams nbytes from 'stream'; toggle=1 offers a byte only on even cycles.
  task automatic load_stream(input int nbytes, input bit toggle,
                             output int cyc, output int rdy_cnt, output int low_cnt);
    int idx;
    bit v;
    bit rdy;
    idx = 0; cyc = 0; rdy_cnt = 0; low_cnt = 0;
    while (idx < nbytes && cyc < 20) begin
      v = toggle ? ((cyc % 2) == 0) : 1'b1;
      boot_valid = v;
      boot_data  = stream[idx];
      @(negedge clock);
      rdy = boot_ready;
      if (rdy) rdy_cnt++;
      if (cpu_reset !== 1'b1) low_cnt++;
      @(posedge clock);
      if (v && rdy) idx++;
      #1;
      cyc++;
    end
    boot_valid = 1'b0;
  endtask

  task automatic enter_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    checkOutput("rst_boot_ready", {15'd0, boot_ready}, 16'd0);
    checkOutput("rst_boot_done", {15'd0, boot_done}, 16'd0);
    @(negedge clock); #1;
    checkOutput("rst_rdata", {8'h00, rdata}, 16'h0000);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; address = 16'h0000; wdata = 8'h00;
    boot_valid = 1'b0; boot_data = 8'h00;

    // Reset state of both instances.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("init_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    checkOutput("init_boot_ready", {15'd0, boot_ready}, 16'd0);
    checkOutput("init_boot_done", {15'd0, boot_done}, 16'd0);
    checkOutput("init_rdata", {8'h00, rdata}, 16'h0000);
    checkOutput("len0_cpu_reset_in_rst", {15'd0, cpu_reset0}, 16'd1);

    // Release: ready immediately; loader idle holds LOAD with no timeout.
    reset = 1'b0;
    #1;
    checkOutput("ready_after_release", {15'd0, boot_ready}, 16'd1);
    @(posedge clock); #1;
    checkOutput("len0_cpu_reset", {15'd0, cpu_reset0}, 16'd0);
    checkOutput("len0_boot_done", {15'd0, boot_done0}, 16'd1);
    checkOutput("idle_still_loading", {15'd0, cpu_reset}, 16'd1);
    checkOutput("idle_ready", {15'd0, boot_ready}, 16'd1);

    // Held-valid load: 4 bytes in 4 cycles.
    stream[0] = 8'h3E; stream[1] = 8'h55; stream[2] = 8'h76; stream[3] = 8'h00;
    load_stream(4, 1'b0, cycles, ready_cnt, cr_low);
    checkOutput("held_cycles", 16'(cycles), 16'd4);
    checkOutput("held_ready_cycles", 16'(ready_cnt), 16'd4);
    checkOutput("held_cpu_reset_low_early", 16'(cr_low), 16'd0);
    checkOutput("held_cpu_reset_after", {15'd0, cpu_reset}, 16'd0);
    checkOutput("held_ready_after", {15'd0, boot_ready}, 16'd0);
    checkOutput("held_boot_done", {15'd0, boot_done}, 16'd1);

    // RUN traffic: readback, half-cycle RAW, protection, write strobe.
    add_vec(1'b0, 16'h0000, 8'h00, 1'b1, 8'h3E);
    add_vec(1'b0, 16'h0001, 8'h00, 1'b1, 8'h55);
    add_vec(1'b0, 16'h0002, 8'h00, 1'b1, 8'h76);
    add_vec(1'b0, 16'h0003, 8'h00, 1'b1, 8'h00);
    add_vec(1'b1, 16'h8000, 8'hA5, 1'b0, 8'h00);
    add_vec(1'b0, 16'h8000, 8'h00, 1'b1, 8'hA5);
    add_vec(1'b1, 16'h0001, 8'hFF, 1'b1, 8'h55);
    add_vec(1'b0, 16'h0001, 8'h00, 1'b1, EXP_RAM1);
    add_vec(1'b1, 16'h4000, 8'h12, 1'b0, 8'h00);
    add_vec(1'b0, 16'h4000, 8'h99, 1'b1, 8'h12);
    add_vec(1'b1, 16'h4001, 8'h34, 1'b0, 8'h00);
    add_vec(1'b1, 16'h4001, 8'h56, 1'b1, 8'h34);
    add_vec(1'b0, 16'h4001, 8'h00, 1'b1, 8'h56);
    add_vec(1'b1, 16'h8001, 8'hC3, 1'b0, 8'h00);
    add_vec(1'b0, 16'h8001, 8'h00, 1'b1, 8'hC3);
    add_vec(1'b0, 16'h8000, 8'h00, 1'b1, 8'hA5);
    run_table();

    // Reset mid-RUN, then toggled-valid load: accepts on cycles 0,2,4,6.
    enter_reset();
    reset = 1'b0;
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    load_stream(4, 1'b1, cycles, ready_cnt, cr_low);
    checkOutput("tog_cycles", 16'(cycles), 16'd7);
    checkOutput("tog_ready_cycles", 16'(ready_cnt), 16'd7);
    checkOutput("tog_cpu_reset_low_early", 16'(cr_low), 16'd0);
    checkOutput("tog_boot_done", {15'd0, boot_done}, 16'd1);
    add_vec(1'b0, 16'h0000, 8'h00, 1'b1, 8'h11);
    add_vec(1'b0, 16'h0001, 8'h00, 1'b1, 8'h22);
    add_vec(1'b0, 16'h0002, 8'h00, 1'b1, 8'h33);
    add_vec(1'b0, 16'h0003, 8'h00, 1'b1, 8'h44);
    add_vec(1'b0, 16'h8000, 8'h00, 1'b1, 8'hA5);
    add_vec(1'b0, 16'h4000, 8'h00, 1'b1, 8'h12);
    run_table();

    // Partial load with CPU write attempts, then reset with a byte offered.
    enter_reset();
    reset = 1'b0;
    we = 1'b1; address = 16'h4000; wdata = 8'h77;
    stream[0] = 8'hAA; stream[1] = 8'hBB;
    load_stream(2, 1'b0, cycles, ready_cnt, cr_low);
    @(negedge clock); #1;
    checkOutput("load_rdata_nop", {8'h00, rdata}, 16'h0000);
    checkOutput("partial_boot_done", {15'd0, boot_done}, 16'd0);
    checkOutput("partial_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    @(posedge clock); #1;
    we = 1'b0;
    boot_valid = 1'b1; boot_data = 8'hCC;
    enter_reset();
    reset = 1'b0;
    boot_valid = 1'b0;
    stream[0] = 8'h3E; stream[1] = 8'h55; stream[2] = 8'h76; stream[3] = 8'h00;
    load_stream(4, 1'b0, cycles, ready_cnt, cr_low);
    checkOutput("reload_cycles", 16'(cycles), 16'd4);
    checkOutput("reload_boot_done", {15'd0, boot_done}, 16'd1);
    add_vec(1'b0, 16'h0000, 8'h00, 1'b1, 8'h3E);
    add_vec(1'b0, 16'h0001, 8'h00, 1'b1, 8'h55);
    add_vec(1'b0, 16'h0002, 8'h00, 1'b1, 8'h76);
    add_vec(1'b0, 16'h0003, 8'h00, 1'b1, 8'h00);
    add_vec(1'b0, 16'h4000, 8'h00, 1'b1, 8'h12);
    run_table();

    checkOutput("len0_ready_never", {15'd0, ready0_seen}, 16'd0);
    checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
